// File: rtl/cmp_pkg.sv
// Package for the shared magnitude-comparator scheduler.
// Contents:
//   cmp_state_t - scheduler FSM states (IDLE -> CMP -> RESP)
//   cmp_res_t   - one-hot compare result {a_gt, b_gt, eq}
//   RES_NONE    - all-zero result, driven whenever no response is valid
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic a_gt;
        logic b_gt;
        logic eq;
    } cmp_res_t;

    localparam cmp_res_t RES_NONE = '0;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude comparator shared by all requesters.
// Build option: CMP_SIGNED_EN defined treats operands as two's complement,
// otherwise they are unsigned. Exactly one result bit is set for any input.
// Ports:
//   a, b - operands, WIDTH bits each
//   res  - {a_gt, b_gt, eq}
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

`ifdef CMP_SIGNED_EN
    logic a_gt, b_gt;
    assign a_gt = $signed(a) > $signed(b);
    assign b_gt = $signed(b) > $signed(a);
`else
    logic a_gt, b_gt;
    assign a_gt = a > b;
    assign b_gt = b > a;
`endif

    assign res.a_gt = a_gt;
    assign res.b_gt = b_gt;
    assign res.eq   = (a == b);

endmodule

// File: rtl/cmp_rr_scheduler.sv
// Round-robin scheduler sharing one comparator among N_REQ requesters.
// A pending request is granted in IDLE (one-cycle req_ready pulse), its
// operands are compared in CMP and the tagged one-hot result is offered in
// RESP until rsp_ready. Build option CMP_SIGNED_EN selects signed compare
// (handled inside cmp_core only).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_valid/a/b     - per-requester request and packed operands
//   req_ready         - one-hot accept pulse
//   rsp_valid/ready   - response handshake
//   rsp_id            - owner of the result
//   rsp_a_gt/b_gt/eq  - one-hot result, all zero outside RESP
module cmp_rr_scheduler
    import cmp_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_a_gt,
    output logic                   rsp_b_gt,
    output logic                   rsp_eq
);

    cmp_state_t       state, state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_r;
    logic [WIDTH-1:0] a_r, b_r;
    cmp_res_t         res_r, core_res, res_out;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  cand;

    // First pending request after rr_ptr, wrapping modulo N_REQ (which need
    // not be a power of two, hence the explicit modulo).
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // req_ready is masked by rst so no accept is signalled in a reset cycle,
    // where the DUT would otherwise drop the request it just acknowledged.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                if (grant_vld && !rst) begin
                    req_ready[grant_id] = 1'b1;
                    state_nxt           = CMP;
                end
            end
            CMP:  state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= ID_W'(N_REQ - 1);
            id_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= RES_NONE;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_vld) begin
                rr_ptr <= grant_id;
                id_r   <= grant_id;
                a_r    <= req_a[int'(grant_id)*WIDTH +: WIDTH];
                b_r    <= req_b[int'(grant_id)*WIDTH +: WIDTH];
            end
            if (state == CMP)
                res_r <= core_res;
        end
    end

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .a   (a_r),
        .b   (b_r),
        .res (core_res)
    );

    // Response fields are forced to zero outside RESP so stale results
    // never leak onto the channel.
    assign rsp_valid = (state == RESP);
    assign rsp_id    = rsp_valid ? id_r  : '0;
    assign res_out   = rsp_valid ? res_r : RES_NONE;
    assign rsp_a_gt  = res_out.a_gt;
    assign rsp_b_gt  = res_out.b_gt;
    assign rsp_eq    = res_out.eq;

endmodule

// File: tb/tb_cmp_rr_scheduler.sv
// Self-checking bench for cmp_rr_scheduler: a reference arbiter/comparator
// model predicts each grant and pushes the expected tagged result to a
// scoreboard; results are popped and compared when the response completes.
// Honours CMP_SIGNED_EN in its reference compare.
module tb_cmp_rr_scheduler;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IW-1:0]  rsp_id;
    logic           rsp_a_gt, rsp_b_gt, rsp_eq;

    cmp_rr_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_a_gt  (rsp_a_gt),
        .rsp_b_gt  (rsp_b_gt),
        .rsp_eq    (rsp_eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [2:0] res;
    } exp_t;

    exp_t       exp_q[$];
    int         glog[$];
    int         n_err = 0;
    int         n_chk = 0;
    int         m_state = 0;   // 0 idle, 1 compare, 2 response
    int         m_ptr = N - 1;
    logic [N-1:0] acc = '0;
    logic [N-1:0] reload = '0;
    logic       rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference compare: bias the sign bit for signed mode, then decide by
    // the borrow of a (W+1)-bit subtraction. Returns {a_gt, b_gt, eq}.
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   ua, ub, d;
        logic [W-1:0] flip;
        flip = '0;
`ifdef CMP_SIGNED_EN
        flip[W-1] = 1'b1;
`endif
        ua = {1'b0, a ^ flip};
        ub = {1'b0, b ^ flip};
        d  = ub - ua;
        if (ua == ub)  return 3'b001;
        else if (d[W]) return 3'b100;
        else           return 3'b010;
    endfunction

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]       = 1'b1;
        req_a[i*W +: W]    = a;
        req_b[i*W +: W]    = b;
    endtask

    // One clock: check outputs at negedge against the model, advance the
    // model, then after the posedge retire accepted requests.
    task automatic tick();
        logic [N-1:0] exp_rdy;
        int           g;
        bit           found;
        exp_t         e;
        @(negedge clk);
        exp_rdy = '0;
        g       = 0;
        found   = 0;
        if (rst) begin
            m_state = 0;
            m_ptr   = N - 1;
            exp_q.delete();
            acc     = '0;
        end else begin
            if (m_state == 0) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (!found && ((req_valid >> idx) & 1) != 0) begin
                        found = 1;
                        g     = idx;
                    end
                end
            end
            if (found) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
            chk("onehot", 32'($countones({rsp_a_gt, rsp_b_gt, rsp_eq})), 32'(rsp_valid));
            if (m_state == 2) begin
                chk("sb_size", 32'(exp_q.size()), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_res", 32'({rsp_a_gt, rsp_b_gt, rsp_eq}), 32'(e.res));
                end
            end else begin
                chk("rsp_idle", 32'({rsp_id, rsp_a_gt, rsp_b_gt, rsp_eq}), 0);
            end
            case (m_state)
                0: if (found) begin
                    e.id  = g;
                    e.res = ref_cmp(req_a[g*W +: W], req_b[g*W +: W]);
                    exp_q.push_back(e);
                    glog.push_back(g);
                    m_ptr   = g;
                    m_state = 1;
                end
                1: m_state = 2;
                default: if (rsp_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    m_state = 0;
                end
            endcase
            acc = exp_rdy;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (reload[i]) begin
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = ($urandom_range(0, 3) == 0) ? req_a[i*W +: W] : W'($urandom);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        acc = '0;
        if (rand_rdy) rsp_ready = 1'($urandom);
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while ((req_valid != '0 || m_state != 0) && c < maxc) begin
            tick();
            c++;
        end
        chk("drain_timeout", 32'(c < maxc), 1);
    endtask

    task automatic wait_state(input int s, input int maxc);
        int c = 0;
        while (m_state != s && c < maxc) begin
            tick();
            c++;
        end
        chk("wait_timeout", 32'(m_state == s), 1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk({tag, "_outs"}, 32'({req_ready, rsp_valid, rsp_id, rsp_a_gt, rsp_b_gt, rsp_eq}), 0);
        glog.delete();
    endtask

    initial begin
        // Reset state
        do_reset("rst0");

        // Single request on requester 0
        rsp_ready = 1'b1;
        issue(0, 8'd9, 8'd3);
        drain(20);
        chk("single_grant", 32'(glog.size() == 1 && glog[0] == 0), 1);

        // All requesters continuously valid from reset
        do_reset("rst1");
        reload = '1;
        for (int i = 0; i < N; i++) issue(i, W'($urandom), W'($urandom));
        repeat (20) tick();
        reload = '0;
        drain(40);
        chk("order_len", 32'(glog.size() >= 5), 1);
        if (glog.size() >= 5) begin
            chk("order0", 32'(glog[0]), 0);
            chk("order1", 32'(glog[1]), 1);
            chk("order2", 32'(glog[2]), 2);
            chk("order3", 32'(glog[3]), 3);
            chk("order4", 32'(glog[4]), 0);
        end

        // Equality with back-pressure; a second request must wait
        rsp_ready = 1'b0;
        issue(2, 8'h5A, 8'h5A);
        wait_state(2, 10);
        issue(1, 8'h10, 8'h20);
        repeat (5) tick();
        rsp_ready = 1'b1;
        drain(20);

        // Signedness corner
        issue(3, 8'hFF, 8'h01);
        drain(20);

        // Reset while comparing requester 1
        do_reset("rst2");
        issue(1, 8'h33, 8'h44);
        wait_state(1, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_cmp_outs", 32'({req_ready, rsp_valid, rsp_id, rsp_a_gt, rsp_b_gt, rsp_eq}), 0);
        chk("rst_cmp_sb", 32'(exp_q.size()), 0);
        glog.delete();
        repeat (3) tick();
        issue(1, 8'h01, 8'h02);
        issue(0, 8'h80, 8'h7F);
        drain(30);
        chk("post_rst_first", 32'(glog.size() > 0 ? glog[0] : -1), 0);

        // Random traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int c = 0; c < 150; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int i;
                i = $urandom_range(0, N - 1);
                if (!req_valid[i]) issue(i, W'($urandom), W'($urandom));
            end
            tick();
        end
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        drain(200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
